sipo_serial_receiver: RTL and testbench
=======================================

# sipo_serial_receiver

Serial-to-parallel receive stage for the serial audio link. It consumes the idle-high, LSB-first serial line produced by the transmit shift register and frames it as start bit, 8 data bits, optional parity bit and stop bit. Each received byte is presented on a parallel bus with a one-cycle valid strobe. It sits at the receive end of the link, feeding the audio sample reassembly logic.

## Interface
- CLKS_PER_BIT, default 434: CLOCK_50 cycles per serial bit, ≥4 (434 gives ≈115200 baud at 50 MHz).
- CLOCK_50, input, 1: single system clock; all logic on its rising edge.
- Reset_n, input, 1: synchronous, active-low reset.
- Serial_In, input, 1: asynchronous serial line, idle high.
- Rx_Data, output, 8: last correctly framed byte; reset 8'h00.
- Rx_Valid, output, 1: one-cycle strobe when Rx_Data updates; reset 0.
- Framing_Error, output, 1: one-cycle strobe on bad stop bit; reset 0.
- Parity_Error, output, 1: one-cycle strobe on parity mismatch; reset 0 (tied 0 when parity is compiled out).
- Rx_Busy, output, 1: high in every state except IDLE; reset 0.

## Operation
- Serial_In passes through a 2-flop synchronizer, which resets to 1. All decisions use the synchronized line (rx_s).
- States:
  - IDLE: on rx_s==0, load the counter and go to START.
  - START: after CLKS_PER_BIT/2 cycles (integer floor), resample rx_s. If 0, go to DATA with bit index 0. If 1, treat it as a glitch and return to IDLE with no strobes.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit [index], LSB first. After bit 7, go to PARITY (if enabled) or STOP.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit and go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit.
    - Stop bit 1 and parity OK: load Rx_Data, pulse Rx_Valid, go to IDLE.
    - Stop bit 1 and parity bad: pulse Parity_Error, leave Rx_Data unchanged, go to IDLE.
    - Stop bit 0: pulse Framing_Error (parity ignored), leave Rx_Data unchanged, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering.
- The bit counter is $clog2(CLKS_PER_BIT) bits wide and the bit index is 3 bits. No arithmetic wraps outside its state.
- Rx_Valid, Framing_Error and Parity_Error are mutually exclusive and never high for two consecutive cycles.
- Rx_Data holds its value until the next valid byte. There is no backpressure: the consumer must take the byte on the Rx_Valid cycle.

## Timing
- Let cycle 0 be the first cycle rx_s==0 in IDLE. With H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT, samples are taken at these cycles:
  - start bit: H
  - data bit i: H+(i+1)·N
  - parity bit: H+9N
  - stop bit: H+9N (no parity) or H+10N (parity)
- Rx_Valid or an error strobe is registered high in the cycle after the stop sample.
- Pin-to-rx_s latency is 2 cycles.
- Back-to-back frames: a start edge arriving in the cycle after returning to IDLE is accepted. The receiver is back in IDLE half a bit before the nominal stop-bit end.
- Reset_n low in any state: next edge forces IDLE, all outputs to reset values and the synchronizer to 1. Any partial frame is discarded.

## Configuration
- SERIAL_RX_PARITY_EN:
  - Defined: frames carry an even-parity bit after bit 7, the PARITY state exists, and Parity_Error is live.
  - Undefined: 10-bit frames (start, 8 data, stop); the PARITY state and its logic are absent; Parity_Error is tied 0.

## Structure
- Shared package serial_link_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - DATA_BITS=8
  - the default CLKS_PER_BIT
  
  The transmit side reuses the same constants.
- One sub-module: serial_bit_sync, the 2-flop synchronizer with a reset value parameter.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Frame 0xA5, parity off -> Rx_Data=8'hA5, Rx_Valid high exactly 1 cycle, at cycle 4+72+1 after rx_s falls; no error strobes.
- Low pulse of 3 cycles on an idle line -> no strobes, Rx_Busy back to 0 by cycle 5, Rx_Data unchanged.
- Frame 0x3C with stop bit 0, line then held low for 40 cycles -> Framing_Error 1 cycle, Rx_Data keeps the previous value, Rx_Busy stays 1 until the line goes high.
- Frames 0x00 then 0xFF sent back-to-back with a single stop bit -> two Rx_Valid strobes carrying 8'h00 and 8'hFF.
- Reset_n low for 1 cycle during data bit 4, then frame 0x5A -> outputs at reset values during reset; only 0x5A is reported afterwards.
- Macro defined: frame 0x07 with parity 0 (wrong) -> Parity_Error 1 cycle and no Rx_Valid. The same frame with parity 1 -> Rx_Data=8'h07 with Rx_Valid.

Source files
------------

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared constants and state encoding for the serial audio link
package serial_link_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/serial_bit_sync.sv
// rtl/serial_bit_sync.sv - two-flop synchronizer with configurable reset value
//
// Ports:
//   i_clk    : system clock
//   i_resetn : synchronous active-low reset, loads RESET_VAL into both flops
//   i_d      : asynchronous input
//   o_q      : synchronized output
module serial_bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sipo_serial_receiver.sv
// rtl/sipo_serial_receiver.sv - serial-to-parallel receiver: start, 8 LSB-first data bits, optional even parity, stop
//
// Build option: define SERIAL_RX_PARITY_EN to expect an even-parity bit after data bit 7.
//
// Ports:
//   CLOCK_50      : system clock, rising edge
//   Reset_n       : synchronous active-low reset
//   Serial_In     : asynchronous serial line, idle high
//   Rx_Data       : last correctly framed byte
//   Rx_Valid      : one-cycle strobe when Rx_Data updates
//   Framing_Error : one-cycle strobe on a low stop bit
//   Parity_Error  : one-cycle strobe on parity mismatch (0 without parity)
//   Rx_Busy       : high whenever the receiver is not idle
module sipo_serial_receiver
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 CLOCK_50,
    input  logic                 Reset_n,
    input  logic                 Serial_In,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Valid,
    output logic                 Framing_Error,
    output logic                 Parity_Error,
    output logic                 Rx_Busy
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_t            r_state, w_state_next;
    logic [CW-1:0]        r_cnt, w_cnt_next;
    logic [2:0]           r_idx, w_idx_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS-1:0] r_data, w_data_next;
    logic                 r_valid, w_valid_next;
    logic                 r_ferr, w_ferr_next;
`ifdef SERIAL_RX_PARITY_EN
    logic                 r_par, w_par_next;
    logic                 r_perr, w_perr_next;
    logic                 w_par_ok;

    // Even parity: data bits plus parity bit hold an even number of ones.
    assign w_par_ok = ~(^{r_shift, r_par});
`endif

    serial_bit_sync #(.RESET_VAL(1'b1)) u_sync (
        .i_clk    (CLOCK_50),
        .i_resetn (Reset_n),
        .i_d      (Serial_In),
        .o_q      (w_rx_s)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_ferr  <= w_ferr_next;
`ifdef SERIAL_RX_PARITY_EN
            r_par   <= w_par_next;
            r_perr  <= w_perr_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        w_par_next   = r_par;
        w_perr_next  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                w_idx_next = '0;
                if (!w_rx_s) w_state_next = START;
            end
            START: begin
                // Mid-start resample rejects short low glitches.
                if (r_cnt == CNT_HALF) begin
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = w_rx_s ? IDLE : DATA;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            DATA: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_next           = '0;
                    w_shift_next[r_idx]  = w_rx_s;
                    if (r_idx == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_next   = '0;
                    w_par_next   = w_rx_s;
                    w_state_next = STOP;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_state_next = IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        if (w_par_ok) begin
                            w_data_next  = r_shift;
                            w_valid_next = 1'b1;
                        end else begin
                            w_perr_next = 1'b1;
                        end
`else
                        w_data_next  = r_shift;
                        w_valid_next = 1'b1;
`endif
                    end else begin
                        // Line still low: wait for it to return high before rearming.
                        w_ferr_next  = 1'b1;
                        w_state_next = BREAK;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            BREAK: begin
                w_cnt_next = '0;
                if (w_rx_s) w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign Rx_Data       = r_data;
    assign Rx_Valid      = r_valid;
    assign Framing_Error = r_ferr;
`ifdef SERIAL_RX_PARITY_EN
    assign Parity_Error  = r_perr;
`else
    assign Parity_Error  = 1'b0;
`endif
    assign Rx_Busy       = (r_state != IDLE);

endmodule

// File: tb/tb_sipo_serial_receiver.sv
// tb/tb_sipo_serial_receiver.sv - directed self-checking bench for sipo_serial_receiver at 8 clocks per bit
module tb_sipo_serial_receiver;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       parity_error;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    int         cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_bad_pulse = 0;
    int         valid_cyc = -1;
    logic [7:0] last_data = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;
    logic       prev_p = 1'b0;

    sipo_serial_receiver #(.CLKS_PER_BIT(8)) dut (
        .CLOCK_50      (clk),
        .Reset_n       (resetn),
        .Serial_In     (serial_in),
        .Rx_Data       (rx_data),
        .Rx_Valid      (rx_valid),
        .Framing_Error (framing_error),
        .Parity_Error  (parity_error),
        .Rx_Busy       (rx_busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid   <= n_valid + 1;
            prev_data <= last_data;
            last_data <= rx_data;
            valid_cyc <= cyc;
        end
        if (framing_error) n_ferr <= n_ferr + 1;
        if (parity_error)  n_perr <= n_perr + 1;
        if ((rx_valid && prev_v) || (framing_error && prev_f) || (parity_error && prev_p) ||
            ((int'(rx_valid) + int'(framing_error) + int'(parity_error)) > 1))
            n_bad_pulse <= n_bad_pulse + 1;
        prev_v <= rx_valid;
        prev_f <= framing_error;
        prev_p <= parity_error;
    end

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
        serial_in = 1'b1;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b expected 0", framing_error); end
        total++; if (parity_error !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b expected 0", parity_error); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        resetn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_frame_a5();
        int v0, f0, p0, t0;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr; t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL a5_valid_count: got %0d expected 1", n_valid - v0); end
        total++; if (last_data !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h expected a5", last_data); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL a5_data_hold: got %h expected a5", rx_data); end
        // 2 sync cycles + (4 + 72 + 1) from rx_s falling.
        total++; if (valid_cyc - t0 !== 79) begin bad++; $display("FAIL a5_latency: got %0d expected 79", valid_cyc - t0); end
        total++; if (n_ferr - f0 !== 0 || n_perr - p0 !== 0) begin bad++; $display("FAIL a5_errors: got %0d/%0d expected 0/0", n_ferr - f0, n_perr - p0); end
        total++; if (n_bad_pulse !== 0) begin bad++; $display("FAIL a5_pulse_shape: got %0d expected 0", n_bad_pulse); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL a5_idle: got %b expected 0", rx_busy); end
    endtask

    task automatic test_glitch();
        int v0, f0, p0;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_start: got %b expected 1", rx_busy); end
        repeat (4) @(negedge clk);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_cycle5: got %b expected 0", rx_busy); end
        repeat (20) @(negedge clk);
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL glitch_valid: got %0d expected 0", n_valid - v0); end
        total++; if (n_ferr - f0 !== 0 || n_perr - p0 !== 0) begin bad++; $display("FAIL glitch_errors: got %0d/%0d expected 0/0", n_ferr - f0, n_perr - p0); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL glitch_data: got %h expected a5", rx_data); end
    endtask

    task automatic test_framing();
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        serial_in = 1'b0;
        repeat (40) @(negedge clk);
        total++; if (n_ferr - f0 !== 1) begin bad++; $display("FAIL framing_count: got %0d expected 1", n_ferr - f0); end
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL framing_valid: got %0d expected 0", n_valid - v0); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL framing_data: got %h expected a5", rx_data); end
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL framing_busy_low: got %b expected 1", rx_busy); end
        serial_in = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL framing_busy_high: got %b expected 0", rx_busy); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (n_valid - v0 !== 2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", n_valid - v0); end
        total++; if (prev_data !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h expected 00", prev_data); end
        total++; if (last_data !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h expected ff", last_data); end
        total++; if (n_ferr - f0 !== 0 || n_bad_pulse !== 0) begin bad++; $display("FAIL b2b_clean: got %0d/%0d expected 0/0", n_ferr - f0, n_bad_pulse); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0, p0;
        logic [7:0] b;
        b = 8'hC3;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        serial_in = b[4];
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data: got %h expected 00", rx_data); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", rx_busy); end
        total++; if (rx_valid !== 1'b0 || framing_error !== 1'b0) begin bad++; $display("FAIL rst_mid_strobes: got %b%b expected 00", rx_valid, framing_error); end
        resetn    = 1'b1;
        serial_in = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL rst_mid_count: got %0d expected 1", n_valid - v0); end
        total++; if (last_data !== 8'h5A) begin bad++; $display("FAIL rst_mid_5a: got %h expected 5a", last_data); end
        total++; if (n_ferr - f0 !== 0 || n_perr - p0 !== 0) begin bad++; $display("FAIL rst_mid_errors: got %0d/%0d expected 0/0", n_ferr - f0, n_perr - p0); end
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        int v0, p0;
        v0 = n_valid; p0 = n_perr;
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (n_perr - p0 !== 1) begin bad++; $display("FAIL parity_bad_count: got %0d expected 1", n_perr - p0); end
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL parity_bad_valid: got %0d expected 0", n_valid - v0); end
        total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL parity_bad_data: got %h expected 5a", rx_data); end
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL parity_ok_count: got %0d expected 1", n_valid - v0); end
        total++; if (rx_data !== 8'h07) begin bad++; $display("FAIL parity_ok_data: got %h expected 07", rx_data); end
        total++; if (n_perr - p0 !== 1) begin bad++; $display("FAIL parity_ok_perr: got %0d expected 1", n_perr - p0); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
